// File: rtl/twiddle_requant_pkg.sv
//------------------------------------------------------------------------------
// Module  : twiddle_requant_pkg
// Purpose : Shared types and helpers for the twiddle product requantiser.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package twiddle_requant_pkg;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Product scaling left by the CSD multipliers: 2^(NBITScoeff-2).
  function automatic int shift_of(input int nbits_coeff);
    return nbits_coeff - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/twiddle_requant_round_sat.sv
//------------------------------------------------------------------------------
// Module  : requant_round_sat
// Purpose : Round one product component by 2^SHIFT and saturate to W_OUT bits.
//           TWIDDLE_REQUANT_ROUND_CONV_EN selects round-half-to-even.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module requant_round_sat #(
  parameter int W_IN  = 24,
  parameter int W_OUT = 13,
  parameter int SHIFT = 9
) (
  input  logic signed [W_IN-1:0]  x,
  output logic signed [W_OUT-1:0] y,
  output logic                    sat
);

  localparam int YW = W_IN - SHIFT + 1;
  localparam logic signed [YW-1:0] Y_MAX = YW'(2 ** (W_OUT - 1) - 1);
  localparam logic signed [YW-1:0] Y_MIN = YW'(-(2 ** (W_OUT - 1)));

  logic signed [YW-1:0] y_up;
  logic signed [YW-1:0] y_r;
  logic                 sat_hi;
  logic                 sat_lo;

  // floor((x + 2^(SHIFT-1)) / 2^SHIFT) == floor(x / 2^SHIFT) + x[SHIFT-1]
  assign y_up = {x[W_IN-1], x[W_IN-1:SHIFT]} + YW'(x[SHIFT-1]);

`ifdef TWIDDLE_REQUANT_ROUND_CONV_EN
  localparam logic [SHIFT-1:0] TIE = SHIFT'(2 ** (SHIFT - 1));
  logic tie;
  assign tie = (x[SHIFT-1:0] == TIE);
  // On an exact tie the two candidates differ by one; keep the even one.
  assign y_r = tie ? {y_up[YW-1:1], 1'b0} : y_up;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^x[SHIFT-2:0];
  assign y_r = y_up;
`endif

  assign sat_hi = (y_r > Y_MAX);
  assign sat_lo = (y_r < Y_MIN);
  assign sat    = sat_hi | sat_lo;
  assign y      = sat_hi ? Y_MAX[W_OUT-1:0] :
                  sat_lo ? Y_MIN[W_OUT-1:0] : y_r[W_OUT-1:0];

endmodule

`default_nettype wire

// File: rtl/twiddle_requant.sv
//------------------------------------------------------------------------------
// Module  : twiddle_requant
// Purpose : Requantise {real, imag} twiddle products to NBITS_q bits through a
//           two-entry valid/ready buffer with frame tagging and sticky
//           saturation flag. Option macro: TWIDDLE_REQUANT_ROUND_CONV_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module twiddle_requant
  import twiddle_requant_pkg::*;
#(
  parameter int NBITS      = 12,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int NBITS_q    = NBITS + 1,
  parameter int FRAME      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NBITS_out-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*NBITS_q-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_last,
  output logic                   sat_flag,
  input  logic                   sat_clr
);

  localparam int SHIFT = shift_of(NBITScoeff);
  localparam int FCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DW    = 2 * NBITS_q;

  logic signed [NBITS_q-1:0] re_rq, im_rq;
  logic                      re_sat, im_sat;

  requant_round_sat #(.W_IN(NBITS_out), .W_OUT(NBITS_q), .SHIFT(SHIFT)) u_rs_re (
    .x   (in_data[2*NBITS_out-1:NBITS_out]),
    .y   (re_rq),
    .sat (re_sat)
  );

  requant_round_sat #(.W_IN(NBITS_out), .W_OUT(NBITS_q), .SHIFT(SHIFT)) u_rs_im (
    .x   (in_data[NBITS_out-1:0]),
    .y   (im_rq),
    .sat (im_sat)
  );

  occ_e           occ_q, occ_d;
  logic [DW-1:0]  mem_q [2];
  logic [DW-1:0]  mem_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           sat_q, sat_d;
  logic           accept, pop;

  // Handshake outputs come straight from registers; out_ready never reaches in_ready.
  assign in_ready   = (occ_q != OCC_FULL);
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign out_data   = mem_q[rd_ptr_q];
  assign frame_last = out_valid & (frame_cnt_q == FCW'(FRAME - 1));
  assign sat_flag   = sat_q;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;

    case (occ_q)
      OCC_EMPTY: if (accept)        occ_d = OCC_ONE;
      OCC_ONE:   if (accept & ~pop) occ_d = OCC_FULL;
                 else if (~accept & pop) occ_d = OCC_EMPTY;
      OCC_FULL:  if (pop)           occ_d = OCC_ONE;
      default:                      occ_d = OCC_EMPTY;
    endcase

    if (accept) begin
      mem_d[wr_ptr_q] = {re_rq, im_rq};
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d    = ~rd_ptr_q;
      frame_cnt_d = (frame_cnt_q == FCW'(FRAME - 1)) ? '0 : frame_cnt_q + 1'b1;
    end

    // A new saturation wins over a coincident clear.
    sat_d = (sat_q & ~sat_clr) | (accept & (re_sat | im_sat));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= OCC_EMPTY;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      frame_cnt_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      sat_q       <= sat_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/twiddle_requant.md
Name: twiddle_requant

Overview:
- Consumes the packed complex product stream from the CSD twiddle multipliers, which produce {real, imag}, each NBITS_out wide and scaled by 2^(NBITScoeff-2).
- Rounds and saturates each component back to NBITS_q bits for the next FFT stage.
- Small buffered valid/ready stage with a frame counter and a sticky saturation flag.
- Sits between each multipCSD_* instance and the following butterfly stage.

Parameters:
- NBITS, 12, sample width at multiplier input
- NBITScoeff, 11, coefficient width; SHIFT = NBITScoeff-2 (default 9)
- NBITS_out, NBITS+NBITScoeff+1, width of each product component
- NBITS_q, NBITS+1, output width per component (one bit of stage growth)
- FRAME, 8, samples per frame; matches the multiplier phase counter period; power of two

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_data  in  2*NBITS_out  {real[2*NBITS_out-1:NBITS_out], imag[NBITS_out-1:0]}, signed
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept
- out_data  out  2*NBITS_q  {real, imag}, signed, requantised
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- frame_last  out  1  out_data is the last sample of a frame (qualified by out_valid)
- sat_flag  out  1  sticky: at least one component saturated
- sat_clr  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (rst=0, async): buffer empty, out_valid=0, in_ready=1 after release, out_data=0, frame counter=0, frame_last=0, sat_flag=0. Any buffered samples are discarded.
- Accept: in_valid & in_ready at a rising edge. Push: transfer out_valid & out_ready.
- Arithmetic, per component, combinational on in_data:
  - t = x + 2^(SHIFT-1), computed at NBITS_out+1 bits.
  - y = t >>> SHIFT (arithmetic shift).
  - If y > 2^(NBITS_q-1)-1, clamp to the maximum; if y < -2^(NBITS_q-1), clamp to the minimum. Either clamp marks the sample as saturated.
- Buffer: 2-entry FIFO of requantised samples.
  - Accepted sample is written at the accept edge.
  - out_data = FIFO head; out_valid = (count != 0).
  - Latency: 1 cycle from accept to out_valid when empty.
- in_ready = (count < 2), derived from registers only; no combinational path from out_ready.
  - Simultaneous accept and pop at count=1 leaves count=1, sustaining 1 sample/clock.
  - Pop at count=2 raises in_ready on the next cycle.
- Order is strictly preserved.
- Frame counter: increments modulo FRAME on each pop. frame_last = out_valid & (counter == FRAME-1). Wraps to 0 after the last pop of a frame.
- sat_flag: set at the accept edge of any saturated sample; cleared by sat_clr. If set and clear occur in the same cycle, set wins.
- out_data holds steady while out_valid & ~out_ready.

Optional Feature:
- TWIDDLE_REQUANT_ROUND_CONV_EN
- Defined: convergent rounding (round half to even). Exact ties (x[SHIFT-1:0] == 2^(SHIFT-1)) round to the even result; all other values behave as round-half-up.
- Undefined: round-half-up as specified above.
- Saturation and timing are identical in both cases.

Decomposition:
- Shared include/package (fft_common): SHIFT derivation, saturation bound constants, the {real, imag} packing macros already used by the multipliers.
- One natural combinational sub-module, requant_round_sat: one component in, rounded/saturated value plus sat bit out. Instantiated twice (real, imag).
- The FIFO, handshake and counter logic stay in the top.

Test Plan:
1. Pass-through phase: real=51200 (100·2^9), imag=-51200, out_ready=1 -> out_data {100, -100} one cycle later, sat_flag=0.
2. Rounding: real=256 -> 1; real=-256 -> 0; real=767 -> 1. With TWIDDLE_REQUANT_ROUND_CONV_EN: 256 -> 0, 768 -> 2.
3. Saturation: real=5000·512, imag=-5000·512 -> {4095, -4096}, sat_flag=1 next cycle. Pulse sat_clr -> 0. sat_clr coincident with a new saturating sample -> sat_flag stays 1.
4. Backpressure:
   - out_ready=0, offer samples A, B, C back-to-back -> A and B accepted, in_ready=0 afterwards, C held.
   - Raise out_ready -> A, B, C emitted in order, no duplicates or drops.
5. Frame: 16 samples at full rate -> frame_last high on transfers 8 and 16 only. Counter survives stalls (random out_ready) with the same count.
6. Reset mid-operation: assert rst with count=2 -> out_valid=0, sat_flag=0, frame counter 0 immediately. The first sample after release is tagged as frame position 0.
